// File: rtl/counter_pkg.sv
// Shared sizing, types and round-robin pick helper for the counter request arbiter
// and its tag FIFO.
package counter_pkg;

    localparam int NUM_REQ      = 4;
    localparam int NUM_COUNTERS = 8;
    localparam int ADDR_W       = $clog2(NUM_COUNTERS);
    localparam int REQ_ID_W     = $clog2(NUM_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    found;
        req_id_t idx;
    } rr_pick_t;

    // First asserted bit of vld at or above ptr, wrapping to zero.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] vld, input req_id_t ptr);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!res.found && vld[req_id_t'(idx)]) begin
                res.found = 1'b1;
                res.idx   = req_id_t'(idx);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_req_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs; the head is visible combinationally so a
// return can be routed in the same cycle it is popped.
module cntr_tag_fifo
    import counter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  req_id_t                push_id_i,
    input  logic                   pop_i,
    output req_id_t                head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    req_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_id_i;
    end

endmodule

// File: rtl/counter_req_arbiter.sv
// Round-robin sharing of one counter increment engine between NUM_REQ requesters;
// returned values are routed back in issue order via the tag FIFO.
module counter_req_arbiter
    import counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int TAG_DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_vld,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [NUM_REQ-1:0]           rsp_vld,
    output logic [COUNTER_WIDTH-1:0]     rsp_val,
    output logic                         cntr_vld_out,
    output logic [ADDR_W-1:0]            cntr_addr_out,
    input  logic [COUNTER_WIDTH-1:0]     cntr_val_in,
    input  logic                         cntr_val_vld_in,
    input  logic                         cntr_init_done,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         orphan_err
);

    req_id_t                  rr_ptr_q, rr_ptr_d;
    logic                     cntr_vld_q;
    logic [ADDR_W-1:0]        cntr_addr_q;
    logic [NUM_REQ-1:0]       rsp_vld_q, rsp_vld_d;
    logic [COUNTER_WIDTH-1:0] rsp_val_q;
    logic                     orphan_q;

    rr_pick_t          pick;
    logic              fifo_full, fifo_empty;
    req_id_t           head_id;
    logic              eligible, accept, pop, orphan;
    logic [ADDR_W-1:0] sel_addr;

    // Fullness is sampled before this cycle's pop, so a pop never frees a slot
    // for a grant in the same cycle.
    assign eligible = !reset && cntr_init_done && !fifo_full;
    assign pick     = rr_pick(req_vld, rr_ptr_q);
    assign accept   = eligible && pick.found;
    assign sel_addr = req_addr[pick.idx*ADDR_W +: ADDR_W];
    assign pop      = cntr_val_vld_in && !fifo_empty;
    assign orphan   = cntr_val_vld_in && fifo_empty;

    always_comb begin
        req_rdy   = '0;
        rr_ptr_d  = rr_ptr_q;
        rsp_vld_d = '0;
        if (accept) begin
            req_rdy[pick.idx] = 1'b1;
            rr_ptr_d = (pick.idx == req_id_t'(NUM_REQ-1)) ? '0 : pick.idx + 1'b1;
        end
        if (pop) rsp_vld_d[head_id] = 1'b1;
    end

    cntr_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (accept),
        .push_id_i (pick.idx),
        .pop_i     (pop),
        .head_o    (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cntr_vld_q  <= 1'b0;
            cntr_addr_q <= '0;
            rsp_vld_q   <= '0;
            rsp_val_q   <= '0;
            orphan_q    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cntr_vld_q <= accept;
            if (accept) cntr_addr_q <= sel_addr;
            rsp_vld_q  <= rsp_vld_d;
            if (pop) rsp_val_q <= cntr_val_in;
            if (orphan) orphan_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept)
            assert (int'(sel_addr) < NUM_COUNTERS)
            else $error("counter_req_arbiter: accepted address %0d out of range", sel_addr);
    end

    assign cntr_vld_out  = cntr_vld_q;
    assign cntr_addr_out = cntr_addr_q;
    assign rsp_vld       = rsp_vld_q;
    assign rsp_val       = rsp_val_q;
    assign orphan_err    = orphan_q;

endmodule

// File: doc/counter_req_arbiter.md
Name: counter_req_arbiter

Overview:
- Shares one multi-counter increment engine between NUM_REQ independent requesters.
- Round-robin arbitration selects at most one increment request per cycle and issues it to the engine's request port.
- The engine returns post-increment values strictly in issue order. The block records the requester ID of every issued request in an in-order tag FIFO, then routes each returned value back to its originator.
- Sits between client logic (e.g. per-port statistics sources) and the counter engine.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- NUM_COUNTERS, 8, counters in the engine; ADDR_W = $clog2(NUM_COUNTERS).
- COUNTER_WIDTH, 32, counter value width.
- TAG_DEPTH, 8, maximum outstanding requests (power of 2). Must be ≥ engine round-trip latency + 2 for full throughput.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_vld  in  NUM_REQ  per-requester request valid
- req_addr  in  NUM_REQ*ADDR_W  packed counter addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_rdy  out  NUM_REQ  per-requester accept (one-hot or zero)
- rsp_vld  out  NUM_REQ  one-hot response strobe
- rsp_val  out  COUNTER_WIDTH  post-increment value for the strobed requester
- cntr_vld_out  out  1  request strobe to the engine
- cntr_addr_out  out  ADDR_W  counter address to the engine
- cntr_val_in  in  COUNTER_WIDTH  engine returned value
- cntr_val_vld_in  in  1  engine return strobe
- cntr_init_done  in  1  engine initialisation complete
- outstanding  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy
- orphan_err  out  1  sticky error flag

Behaviour:
- Reset values: req_rdy=0, rsp_vld=0, rsp_val=0, cntr_vld_out=0, cntr_addr_out=0, outstanding=0, orphan_err=0. RR pointer=0, FIFO empty.
- Gating: no grant is issued while cntr_init_done=0, i.e. req_rdy=0 for all requesters.
- Arbitration (combinational):
  - eligible = init_done && (outstanding < TAG_DEPTH).
  - If eligible, grant the first requester with req_vld=1, searching from rr_ptr upward with wrap.
  - req_rdy[g]=1 only for the granted requester g.
  - A pop in the same cycle does not free a slot for that cycle.
- Accept: occurs on req_vld[g] && req_rdy[g]. At the next edge:
  - cntr_vld_out<=1 and cntr_addr_out<=req_addr slice g, so the engine sees the request 1 cycle after accept.
  - Push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No accept: cntr_vld_out<=0, cntr_addr_out holds its value, rr_ptr holds.
- Requester obligation: hold req_vld and req_addr stable until accepted. Dropping req_vld before accept is legal; the request is simply lost.
- Return path:
  - On cntr_val_vld_in=1 with the FIFO non-empty: pop the head ID h.
  - Next cycle: rsp_vld=one-hot(h), rsp_val=cntr_val_in.
  - Otherwise rsp_vld=0 and rsp_val holds.
- Responses carry no backpressure; requesters must always sink them.
- Simultaneous push and pop: both occur and outstanding is unchanged. This is legal when full (the pop occurs; no push is possible because the grant was blocked).
- Orphan return: cntr_val_vld_in while the FIFO is empty sets orphan_err=1 (sticky until reset). No rsp_vld is asserted and FIFO state is unchanged.
- Mid-operation reset: FIFO flushed, pointers cleared, all outputs return to reset values at the next edge. Returns still in flight in the engine are also reset, because engine and arbiter share reset.
- Engine address rule: cntr_addr_out is always < NUM_COUNTERS. An out-of-range req_addr is an assertion error at accept.
- Throughput: 1 request per cycle aggregate. Round-robin guarantees that a requester holding req_vld is granted within NUM_REQ eligible cycles.

Decomposition:
- Package counter_pkg: ADDR_W and REQ_ID_W localparams (functions of parameters), req_id_t typedef, and a pure function rr_pick(vld, ptr) returning the grant index and a found flag.
- Sub-module cntr_tag_fifo:
  - Synchronous FIFO of req_id_t, depth TAG_DEPTH.
  - push/pop/full/empty/count ports; pop-head is readable combinationally.
  - Reused by the engine's future multi-port front ends.

Test Plan:
- Init gating: hold cntr_init_done=0 for 10 cycles with req_vld=4'b1111 → req_rdy=0 throughout. Raise cntr_init_done → req_rdy=4'b0001 in the same cycle.
- Round-robin fairness: all four requesters continuously valid for 8 accepts → grant order 0,1,2,3,0,1,2,3 and cntr_vld_out high for 8 consecutive cycles.
- Routing: requester 2 (addr 5) and requester 0 (addr 5) accepted back-to-back; engine returns 1 then 2 → rsp_vld=4'b0100 with rsp_val=1, then rsp_vld=4'b0001 with rsp_val=2, in consecutive cycles.
- Full backpressure: with TAG_DEPTH=8, stall engine returns and issue 8 accepts → outstanding=8 and req_rdy=0. One return → outstanding=7 the next cycle and exactly one further grant.
- Orphan: pulse cntr_val_vld_in with the FIFO empty → orphan_err=1 and stays set, rsp_vld=0. After reset: orphan_err=0.
- Reset mid-flight: 3 outstanding, assert reset for 1 cycle → outstanding=0, cntr_vld_out=0, rr_ptr=0. The first post-init grant goes to requester 0.
